// File: rtl/alu_packet_parser.sv
// ---------------------------------------------------------------------------
// alu_packet_parser
//
// Parses a byte stream from the UART RX path into ALU operand transfers.
// Packet layout: opcode, reserved, LEN[7:0], LEN[15:8], then (LEN-4)/4
// little-endian 32-bit operands. Malformed packets (bad opcode or bad LEN)
// produce a one-cycle error pulse, and their payload is then discarded.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   s_axis_tdata/tvalid : received byte stream (input side)
//   s_axis_tready       : parser can accept a byte this cycle
//   m_opcode            : opcode of the packet being parsed
//   m_operand           : assembled 32-bit operand
//   m_valid / m_ready   : operand handshake toward the ALU
//   m_first / m_last    : operand position markers within its packet
//   error               : one-cycle pulse when a packet is rejected
//   busy                : parser is not in IDLE
// ---------------------------------------------------------------------------
module alu_packet_parser #(
    parameter int unsigned MAX_LEN_P = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_opcode,
    output logic [31:0] m_operand,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_first,
    output logic        m_last,
    output logic        error,
    output logic        busy
);

    localparam logic [16:0] MAX_LEN_L = 17'(MAX_LEN_P);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RSV     = 3'd1,
        LEN_LO  = 3'd2,
        LEN_HI  = 3'd3,
        PAYLOAD = 3'd4,
        OUT     = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    state_e      state_q,     state_d;
    logic [7:0]  opcode_q,    opcode_d;
    logic [7:0]  len_lo_q,    len_lo_d;
    logic [31:0] operand_q,   operand_d;
    logic [1:0]  byte_cnt_q,  byte_cnt_d;   // payload bytes held for the current operand
    logic [13:0] op_cnt_q,    op_cnt_d;     // operands still to be handed over
    logic [15:0] drain_cnt_q, drain_cnt_d;  // bytes left to discard
    logic        first_q,     first_d;
    logic        error_q,     error_d;

    logic        ready_int;
    logic        xfer;
    logic        op_xfer;
    logic [15:0] len_w;
    logic        opcode_ok;
    logic        len_ok;

    // The stream is accepted everywhere except while an operand waits for
    // the ALU; rst additionally forces tready low at the port.
    assign ready_int = (state_q != OUT);
    assign xfer      = s_axis_tvalid && ready_int;
    assign op_xfer   = (state_q == OUT) && m_ready;

    // LEN is only complete on the LEN_HI byte, so legality is judged from
    // the live high byte plus the captured low byte.
    assign len_w     = {s_axis_tdata, len_lo_q};
    assign opcode_ok = (opcode_q == 8'h20) || (opcode_q == 8'h21) || (opcode_q == 8'h22);
    assign len_ok    = (len_w >= 16'd12) && ({1'b0, len_w} <= MAX_LEN_L) && (len_w[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        operand_d   = operand_q;
        byte_cnt_d  = byte_cnt_q;
        op_cnt_d    = op_cnt_q;
        drain_cnt_d = drain_cnt_q;
        first_d     = first_q;
        error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    opcode_d = s_axis_tdata;
                    state_d  = RSV;
                end
            end
            RSV: begin
                if (xfer) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_lo_d = s_axis_tdata;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    if (opcode_ok && len_ok) begin
                        // (LEN-4)/4 == LEN/4 - 1; LEN >= 12 so this is >= 2
                        op_cnt_d   = len_w[15:2] - 14'd1;
                        byte_cnt_d = 2'd0;
                        first_d    = 1'b1;
                        state_d    = PAYLOAD;
                    end else begin
                        error_d = 1'b1;
                        if (len_w > 16'd4) begin
                            drain_cnt_d = len_w - 16'd4;
                            state_d     = DRAIN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    // Little-endian: each new byte enters at the top, so the
                    // first byte ends up in [7:0] after four shifts.
                    operand_d  = {s_axis_tdata, operand_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (op_xfer) begin
                    op_cnt_d = op_cnt_q - 14'd1;
                    first_d  = 1'b0;
                    state_d  = (op_cnt_q == 14'd1) ? IDLE : PAYLOAD;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    drain_cnt_d = drain_cnt_q - 16'd1;
                    if (drain_cnt_q == 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= 8'h00;
            len_lo_q    <= 8'h00;
            operand_q   <= 32'h0;
            byte_cnt_q  <= 2'd0;
            op_cnt_q    <= 14'd0;
            drain_cnt_q <= 16'd0;
            first_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            operand_q   <= operand_d;
            byte_cnt_q  <= byte_cnt_d;
            op_cnt_q    <= op_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            first_q     <= first_d;
            error_q     <= error_d;
        end
    end

    // Outputs are forced to zero for the whole time rst is high, not just
    // from the first reset edge onward.
    assign s_axis_tready = ready_int && !rst;
    assign m_opcode      = rst ? 8'h00 : opcode_q;
    assign m_operand     = rst ? 32'h0 : operand_q;
    assign m_valid       = (state_q == OUT) && !rst;
    assign m_first       = (state_q == OUT) && first_q && !rst;
    assign m_last        = (state_q == OUT) && (op_cnt_q == 14'd1) && !rst;
    assign error         = error_q && !rst;
    assign busy          = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_alu_packet_parser.sv
module tb_alu_packet_parser;

    localparam int MAX_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_opcode;
    logic [31:0] m_operand;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_last;
    logic        error;
    logic        busy;

    always #5 clk = ~clk;

    alu_packet_parser #(.MAX_LEN_P(MAX_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_opcode      (m_opcode),
        .m_operand     (m_operand),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_first       (m_first),
        .m_last        (m_last),
        .error         (error),
        .busy          (busy)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  opc;
        logic [31:0] opd;
        bit          first;
        bit          last;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] pkt[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         ready_mode = 0;   // 0: random m_ready, 1: m_ready held low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: reads the whole packet and lists the events it must cause.
    task automatic send_pkt();
        int  len;
        bit  ok;
        ev_t e;
        len = {pkt[3], pkt[2]};
        ok  = (pkt[0] inside {8'h20, 8'h21, 8'h22}) && len >= 12 && len <= MAX_LEN && (len % 4) == 0;
        if (ok) begin
            for (int i = 0; i < (len - 4) / 4; i++) begin
                e.is_err = 1'b0;
                e.opc    = pkt[0];
                e.opd    = {pkt[4*i+7], pkt[4*i+6], pkt[4*i+5], pkt[4*i+4]};
                e.first  = (i == 0);
                e.last   = (i == (len - 4) / 4 - 1);
                exp_q.push_back(e);
            end
        end else begin
            e = '{is_err: 1'b1, opc: 8'h00, opd: 32'h0, first: 1'b0, last: 1'b0};
            exp_q.push_back(e);
        end
        foreach (pkt[i]) tx_q.push_back(pkt[i]);
    endtask

    // Builds a packet whose byte count matches what the parser will consume.
    task automatic gen_pkt(input logic [7:0] opc, input int len);
        int  total;
        bit  ok;
        ok    = (opc inside {8'h20, 8'h21, 8'h22}) && len >= 12 && len <= MAX_LEN && (len % 4) == 0;
        total = ok ? len : ((len > 4) ? len : 4);
        pkt.delete();
        pkt.push_back(opc);
        pkt.push_back(8'($urandom));
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        for (int i = 4; i < total; i++) pkt.push_back(8'($urandom));
        send_pkt();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0 || busy) && t < 8000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("idle_within_budget", 32'(t < 8000), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_opcode"}, 32'(m_opcode), 32'h0);
        chk({tag, "_operand"}, m_operand, 32'h0);
        chk({tag, "_flags"}, 32'({m_valid, m_first, m_last, error, busy, s_axis_tready}), 32'h0);
    endtask

    // Byte driver: random valid gaps, garbage data when not valid.
    initial begin : drv
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = tx_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'($urandom);
            end
            #1;
            if (s_axis_tvalid && s_axis_tready) void'(tx_q.pop_front());
        end
    end

    initial begin : rdy
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT produces an event.
    initial begin : mon
        bit          hold;
        logic [7:0]  p_opc;
        logic [31:0] p_opd;
        logic        p_f;
        logic        p_l;
        ev_t         e;
        hold = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (error) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_error: got error pulse, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_error", 32'(e.is_err), 32'd1);
                end
            end
            if (m_valid) begin
                chk("tready_low_in_out", 32'(s_axis_tready), 32'd0);
                if (hold) begin
                    chk("stable_opcode", 32'(m_opcode), 32'(p_opc));
                    chk("stable_operand", m_operand, p_opd);
                    chk("stable_first_last", 32'({m_first, m_last}), 32'({p_f, p_l}));
                end
                if (m_ready) begin
                    hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_operand: got 0x%08h, expected none", m_operand);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_is_operand", 32'(e.is_err), 32'd0);
                        chk("opcode", 32'(m_opcode), 32'(e.opc));
                        chk("operand", m_operand, e.opd);
                        chk("first", 32'(m_first), 32'(e.first));
                        chk("last", 32'(m_last), 32'(e.last));
                    end
                end else begin
                    hold  = 1'b1;
                    p_opc = m_opcode;
                    p_opd = m_operand;
                    p_f   = m_first;
                    p_l   = m_last;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin : main
        int t;
        int len;
        logic [7:0] opc;
        logic [7:0] bad_opc[5];
        int         bad_len[7];
        bad_opc = '{8'h00, 8'h1F, 8'h23, 8'h55, 8'hFF};
        bad_len = '{0, 2, 4, 6, 10, 13, 30};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Legal add, two operands
        pkt = '{8'h20, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        wait_idle();

        // Backpressure on the first operand
        ready_mode = 1;
        send_pkt();
        t = 0;
        while (!m_valid && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("bp_valid_seen", 32'(m_valid), 32'd1);
        repeat (10) begin
            chk("bp_valid_held", 32'(m_valid), 32'd1);
            chk("bp_operand_held", m_operand, 32'h0000_0005);
            chk("bp_tready_low", 32'(s_axis_tready), 32'd0);
            @(negedge clk); #1;
        end
        ready_mode = 0;
        wait_idle();

        // Illegal opcode with drain, then a legal packet
        pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_pkt();
        gen_pkt(8'h21, 16);
        wait_idle();

        // Illegal length 10 (not a multiple of 4, below minimum)
        pkt = '{8'h21, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt();
        wait_idle();

        // Short length: straight back to IDLE, next byte is an opcode
        pkt = '{8'h22, 8'h00, 8'h02, 8'h00};
        send_pkt();
        gen_pkt(8'h22, 12);
        wait_idle();

        // Reset after the 6th byte of a legal packet
        pkt = '{8'h20, 8'h00, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 6; i++) tx_q.push_back(pkt[i]);
        t = 0;
        while (tx_q.size() != 0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("six_bytes_sent", 32'(tx_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset_a");
        @(negedge clk); #1;
        chk_reset_outputs("midreset_b");
        @(negedge clk);
        rst = 1'b0;
        gen_pkt(8'h20, 20);
        wait_idle();

        // Randomized back-to-back stream
        for (int n = 0; n < 40; n++) begin
            opc = ($urandom_range(0, 9) < 8) ? 8'(8'h20 + $urandom_range(0, 2))
                                             : bad_opc[$urandom_range(0, 4)];
            len = ($urandom_range(0, 9) < 8) ? 12 + 4 * $urandom_range(0, 12)
                                             : bad_len[$urandom_range(0, 6)];
            gen_pkt(opc, len);
        end
        wait_idle();

        // Length boundaries around MAX_LEN
        gen_pkt(8'h21, MAX_LEN);
        wait_idle();
        gen_pkt(8'h20, MAX_LEN + 4);
        gen_pkt(8'h20, 12);
        wait_idle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_packet_parser.md
ALU_PACKET_PARSER -- requirements
Module: alu_packet_parser

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, and all state SHALL update on the rising edge of clk.
REQ-002 Parameter MAX_LEN_P, default 1024: largest legal packet length in bytes, header included.
REQ-003 Port clk, input, 1: system clock, the PLL output domain shared with the UART.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port s_axis_tdata, input, 8: received byte from the UART RX master stream.
REQ-006 Port s_axis_tvalid, input, 1: received byte valid.
REQ-007 Port s_axis_tready, output, 1: parser accepts the byte.
REQ-008 Port m_opcode, output, 8: opcode of the current packet.
REQ-009 Port m_operand, output, 32: assembled operand, little-endian.
REQ-010 Port m_valid, output, 1: operand valid.
REQ-011 Port m_ready, input, 1: downstream ALU accepts the operand.
REQ-012 Port m_first, output, 1: operand is the first of its packet.
REQ-013 Port m_last, output, 1: operand is the last of its packet.
REQ-014 Port error, output, 1: one-cycle pulse when a packet is rejected.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 Packet format SHALL be: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8], then (LEN-4)/4 operands of 4 bytes each, least-significant byte first.
REQ-017 Legal opcodes SHALL be 0x20 (add), 0x21 (mul) and 0x22 (div); any other value is illegal.
REQ-018 LEN SHALL be legal only when 12 <= LEN <= MAX_LEN_P and LEN[1:0] == 0.
REQ-019 The FSM states SHALL be IDLE, RSV, LEN_LO, LEN_HI, PAYLOAD, OUT and DRAIN.
REQ-020 A byte transfers only on a cycle where s_axis_tvalid and s_axis_tready are both high.
REQ-021 FSM transitions SHALL be:
- IDLE→RSV on a transfer; the opcode is captured.
- RSV→LEN_LO on a transfer.
- LEN_LO→LEN_HI on a transfer.
- LEN_HI→PAYLOAD on a transfer when the opcode and LEN are both legal.
REQ-022 On the LEN_HI transfer, if the opcode or LEN is illegal, the block SHALL pulse error for one cycle, the next cycle; it then goes to DRAIN when LEN > 4, otherwise to IDLE.
REQ-023 DRAIN SHALL accept and discard exactly LEN-4 bytes, then return to IDLE with no output produced.
REQ-024 PAYLOAD SHALL shift in bytes until 4 are held; on the 4th transfer the block SHALL go to OUT and assert m_valid in the following cycle (latency 1).
REQ-025 s_axis_tready SHALL be 1 in IDLE, RSV, LEN_LO, LEN_HI, PAYLOAD and DRAIN, and 0 in OUT and during rst.
REQ-026 In OUT, m_operand, m_opcode, m_first and m_last SHALL stay stable while m_valid is high and m_ready is low.
REQ-027 When m_valid and m_ready are both high, the block SHALL:
- go to IDLE if m_last is set, otherwise to PAYLOAD;
- drop m_valid in the next cycle.
REQ-028 An operand counter SHALL be loaded with (LEN-4)/4 and decremented on each operand transfer.
REQ-029 m_last SHALL be 1 exactly when the presented operand is the final one in the count.
REQ-030 m_first SHALL be 1 only for the first operand of a packet.
REQ-031 m_ready is ignored when m_valid is low.
REQ-032 Back-to-back packets SHALL be supported: the opcode byte of the next packet is accepted in the cycle after returning to IDLE, with no lost bytes.
REQ-033 s_axis_tdata is ignored whenever no transfer occurs.

Reset
REQ-034 While rst is high, the block SHALL:
- force the FSM to IDLE;
- clear the byte and operand counters;
- drive m_opcode=0, m_operand=0, m_valid=0, m_first=0, m_last=0, error=0, busy=0 and s_axis_tready=0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet without an error pulse; parsing SHALL restart at IDLE on the first cycle after rst deasserts.

Verification
REQ-036 Legal add: send 20 00 0C 00 05 00 00 00 07 00 00 00 -> two operands 0x00000005 (first=1, last=0) then 0x00000007 (first=0, last=1), opcode=0x20, error never asserted.
REQ-037 Backpressure: same packet with m_ready held 0 for 10 cycles -> m_valid and m_operand=0x00000005 stable, s_axis_tready=0 throughout; transfer completes when m_ready rises.
REQ-038 Illegal opcode: send 55 00 08 00 AA BB CC DD, then a legal packet -> one error pulse, 4 bytes drained, then the legal packet parsed correctly.
REQ-039 Illegal length: send 21 00 0A 00 followed by 6 bytes -> one error pulse, 6 bytes drained, no m_valid.
REQ-040 Short length: send 22 00 02 00 -> one error pulse, back to IDLE immediately; the next byte is treated as an opcode.
REQ-041 Reset mid-packet: assert rst after the 6th byte of a legal packet -> all outputs 0, no error pulse; the following legal packet is parsed correctly.
